// File: rtl/edge_frame_packer.sv
// Edge-frame packer: captures one frame of binary edge pixels on request,
// packs them MSB-first into bytes (zero-padding each line's final byte),
// and streams the bytes out through a small show-ahead FIFO with a
// frame-complete tlast tag.
module edge_frame_packer #(
  parameter int WIDTH      = 8,
  parameter int H_RES      = 172,
  parameter int V_RES      = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_capture,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [WIDTH-1:0] i_data,
  output logic [7:0]       o_tdata,
  output logic             o_tvalid,
  input  logic             i_tready,
  output logic             o_tlast,
  output logic             o_busy,
  output logic             o_error
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

  state_t           state_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       pack_reg;
  logic             vsync_prev_reg;
  logic             error_reg;
  logic             busy_reg;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [8:0]       mem [FIFO_DEPTH];

  logic       vsync_rise;
  logic       pix_bit;
  logic       pix_take;
  logic       line_end;
  logic       frame_end;
  logic [7:0] pack_merged;
  logic       push_valid;
  logic       push_last;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       wr_en;
  logic       overflow;
  logic [8:0] head;

  // Line sync carries no information we need; lower pixel bits are redundant
  // because edge pixels are all-zeros or all-ones.
  logic unused_inputs;
  assign unused_inputs = ^{i_hsync, i_data};

  assign vsync_rise = i_vsync & ~vsync_prev_reg;
  assign pix_bit    = i_data[WIDTH-1];
  // A vsync rise in the same cycle as a pixel wins: the frame is truncated.
  assign pix_take   = (state_reg == CAPTURE) && i_de && !vsync_rise;
  assign line_end   = (col_reg == COL_W'(H_RES - 1));
  assign frame_end  = line_end && (row_reg == ROW_W'(V_RES - 1));

  // Drop the incoming pixel into its slot; bits not yet filled stay zero,
  // which gives the pad bits for a short final byte for free.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pack
      assign pack_merged[gi] = (bit_cnt_reg == 3'(7 - gi)) ? pix_bit : pack_reg[gi];
    end
  endgenerate

  assign push_valid = pix_take && ((bit_cnt_reg == 3'd7) || line_end);
  assign push_last  = pix_take && frame_end;

  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign pop        = !fifo_empty && i_tready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en      = push_valid && (!fifo_full || pop);
  assign overflow   = push_valid && fifo_full && !pop;

  assign head     = mem[rd_ptr_reg];
  assign o_tvalid = !fifo_empty;
  assign o_tdata  = o_tvalid ? head[7:0] : 8'h00;
  assign o_tlast  = o_tvalid & head[8];
  assign o_busy   = busy_reg;
  assign o_error  = error_reg;

  // Capture control FSM with frame/line counters, packer and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      bit_cnt_reg    <= '0;
      pack_reg       <= '0;
      vsync_prev_reg <= 1'b0;
      error_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      vsync_prev_reg <= i_vsync;
      case (state_reg)
        IDLE: begin
          if (i_capture) begin
            state_reg   <= ARM;
            busy_reg    <= 1'b1;
            error_reg   <= 1'b0;
            col_reg     <= '0;
            row_reg     <= '0;
            bit_cnt_reg <= '0;
            pack_reg    <= '0;
          end
        end
        ARM: begin
          if (vsync_rise) state_reg <= CAPTURE;
        end
        CAPTURE: begin
          if (vsync_rise) begin
            error_reg   <= 1'b1;
            pack_reg    <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= DRAIN;
          end else if (i_de) begin
            if (overflow) error_reg <= 1'b1;
            if (push_valid) begin
              pack_reg    <= '0;
              bit_cnt_reg <= '0;
            end else begin
              pack_reg    <= pack_merged;
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            if (line_end) begin
              col_reg <= '0;
              row_reg <= row_reg + ROW_W'(1);
              if (frame_end) state_reg <= DRAIN;
            end else begin
              col_reg <= col_reg + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage: data byte plus tlast tag; contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {push_last, pack_merged};
  end

endmodule

// File: tb/tb_edge_frame_packer.sv
// Directed bench for edge_frame_packer: per-line packing vectors from a table,
// then full-frame, backpressure, truncation, capture-ignore and reset sequences.
module tb_edge_frame_packer;

  localparam int WIDTH       = 8;
  localparam int H_RES       = 172;
  localparam int V_RES       = 120;
  localparam int FIFO_DEPTH  = 16;
  localparam int BPL         = 22;          // ceil(172/8)
  localparam int FRAME_BYTES = V_RES * BPL; // 2640

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             i_capture = 1'b0;
  logic             i_vsync = 1'b0;
  logic             i_hsync = 1'b0;
  logic             i_de = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic [7:0]       o_tdata;
  logic             o_tvalid;
  logic             i_tready = 1'b1;
  logic             o_tlast;
  logic             o_busy;
  logic             o_error;

  always #5 clk = ~clk;

  edge_frame_packer #(
    .WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .i_capture(i_capture), .i_vsync(i_vsync),
    .i_hsync(i_hsync), .i_de(i_de), .i_data(i_data), .o_tdata(o_tdata),
    .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tlast(o_tlast),
    .o_busy(o_busy), .o_error(o_error)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] rx_q[$];

  // Record every accepted byte {tlast, tdata}, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn && o_tvalid && i_tready) rx_q.push_back({o_tlast, o_tdata});
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    i_capture = 1'b1; step();
    i_capture = 1'b0; step();
    i_vsync = 1'b1;   step();
    i_vsync = 1'b0;   step();
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1; step();
    i_vsync = 1'b0; step();
  endtask

  // Pixel c is on when mask[7 - c%8] is set (or, head_only, when c < 8).
  // A 3-cycle de gap with junk data is inserted before column 50.
  task automatic send_pixels(input logic [7:0] mask, input logic [7:0] on_v,
                             input logic [7:0] off_v, input int npix, input bit head_only);
    for (int c = 0; c < npix; c++) begin
      if (c == 50) begin
        i_de = 1'b0;
        i_data = on_v;
        repeat (3) step();
      end
      i_de = 1'b1;
      if (head_only) i_data = (c < 8) ? on_v : off_v;
      else           i_data = mask[7 - (c % 8)] ? on_v : off_v;
      step();
    end
    i_de = 1'b0;
    i_data = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      step();
      n++;
    end
    check(name, o_busy, 1'b0);
  endtask

  function automatic int count_tlast();
    int n;
    n = 0;
    foreach (rx_q[i]) if (rx_q[i][8]) n++;
    return n;
  endfunction

  typedef struct {
    logic [7:0] mask;
    logic [7:0] on_v;
    logic [7:0] off_v;
    logic [7:0] exp_full;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bad;
    int hold_bad;

    vecs[0] = '{8'h80, 8'hFF, 8'h00, 8'h80, 8'h80};
    vecs[1] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hF0};
    vecs[2] = '{8'h0F, 8'hFF, 8'h00, 8'h0F, 8'h00};
    vecs[3] = '{8'hA5, 8'hFF, 8'h00, 8'hA5, 8'hA0};
    vecs[4] = '{8'hC3, 8'h80, 8'h7F, 8'hC3, 8'hC0};
    vecs[5] = '{8'h01, 8'hFF, 8'h00, 8'h01, 8'h00};

    // Reset state
    #2;
    check("reset tvalid", o_tvalid, 1'b0);
    check("reset tlast", o_tlast, 1'b0);
    check("reset busy", o_busy, 1'b0);
    check("reset error", o_error, 1'b0);
    check("reset tdata", o_tdata, 8'h00);
    step(); step();
    rstn = 1'b1;
    step();
    check("idle busy after reset", o_busy, 1'b0);
    $display("reset: outputs checked");

    // Single-line packing vectors, each closed by a truncating vsync
    for (int v = 0; v < 6; v++) begin
      rx_q.delete();
      start_frame();
      send_pixels(vecs[v].mask, vecs[v].on_v, vecs[v].off_v, H_RES, 1'b0);
      step();
      vsync_pulse();
      wait_idle($sformatf("vec%0d idle", v), 200);
      check($sformatf("vec%0d byte count", v), rx_q.size(), BPL);
      if (rx_q.size() == BPL) begin
        bad = 0;
        for (int i = 0; i < BPL - 1; i++) if (rx_q[i][7:0] !== vecs[v].exp_full) bad++;
        check($sformatf("vec%0d body bad bytes", v), bad, 0);
        check($sformatf("vec%0d last byte", v), rx_q[BPL-1][7:0], vecs[v].exp_last);
      end
      check($sformatf("vec%0d tlast count", v), count_tlast(), 0);
      check($sformatf("vec%0d error", v), o_error, 1'b1);
      $display("vec%0d: mask=%02h bytes=%0d", v, vecs[v].mask, rx_q.size());
    end

    // Full frame of 0x80 bytes; a capture request mid-frame must be ignored
    rx_q.delete();
    start_frame();
    for (int r = 0; r < V_RES; r++) begin
      if (r == 10) begin
        i_capture = 1'b1; step();
        i_capture = 1'b0;
        check("capture-ignore busy", o_busy, 1'b1);
        check("capture-ignore error", o_error, 1'b0);
      end
      send_pixels(8'h80, 8'hFF, 8'h00, H_RES, 1'b0);
    end
    wait_idle("frame idle", 500);
    check("frame byte count", rx_q.size(), FRAME_BYTES);
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i][7:0] !== 8'h80) bad++;
    check("frame bad bytes", bad, 0);
    check("frame tlast count", count_tlast(), 1);
    if (rx_q.size() > 0) check("frame tlast on final byte", rx_q[rx_q.size()-1][8], 1'b1);
    check("frame error", o_error, 1'b0);
    $display("frame: bytes=%0d tlast=%0d", rx_q.size(), count_tlast());

    // Whole frame with the sink stalled: FIFO fills, head holds, error set
    rx_q.delete();
    i_tready = 1'b0;
    start_frame();
    hold_bad = 0;
    for (int r = 0; r < V_RES; r++) begin
      send_pixels(8'h3C, 8'hFF, 8'h00, H_RES, r == 0);
      if (o_tvalid !== 1'b1 || o_tdata !== 8'hFF) hold_bad++;
    end
    step(); step(); step();
    check("stall hold samples", hold_bad, 0);
    check("stall tvalid", o_tvalid, 1'b1);
    check("stall tdata", o_tdata, 8'hFF);
    check("stall tlast", o_tlast, 1'b0);
    check("stall error", o_error, 1'b1);
    check("stall busy", o_busy, 1'b1);
    i_tready = 1'b1;
    wait_idle("stall drain idle", 100);
    check("stall drained count", rx_q.size(), FIFO_DEPTH);
    if (rx_q.size() > 0) check("stall first byte", rx_q[0][7:0], 8'hFF);
    bad = 0;
    for (int i = 1; i < rx_q.size(); i++) if (rx_q[i][7:0] !== 8'h00) bad++;
    check("stall later bytes", bad, 0);
    check("stall tlast count", count_tlast(), 0);
    $display("stall: drained=%0d", rx_q.size());

    // Second vsync at row 100, 13 pixels into the line
    rx_q.delete();
    start_frame();
    for (int r = 0; r < 100; r++) send_pixels(8'h80, 8'hFF, 8'h00, H_RES, 1'b0);
    send_pixels(8'hFF, 8'hFF, 8'h00, 13, 1'b0);
    vsync_pulse();
    wait_idle("trunc idle", 200);
    check("trunc byte count", rx_q.size(), 100 * BPL + 1);
    if (rx_q.size() == 100 * BPL + 1) check("trunc last byte", rx_q[100*BPL][7:0], 8'hFF);
    check("trunc tlast count", count_tlast(), 0);
    check("trunc error", o_error, 1'b1);
    $display("trunc: bytes=%0d", rx_q.size());

    // Reset mid-line 50 with bytes queued
    rx_q.delete();
    start_frame();
    for (int r = 0; r < 50; r++) begin
      if (r == 48) i_tready = 1'b0;
      send_pixels(8'h80, 8'hFF, 8'h00, H_RES, 1'b0);
    end
    send_pixels(8'hFF, 8'hFF, 8'h00, 30, 1'b0);
    check("pre-reset tvalid", o_tvalid, 1'b1);
    rstn = 1'b0;
    #1;
    check("mid reset tvalid", o_tvalid, 1'b0);
    check("mid reset tlast", o_tlast, 1'b0);
    check("mid reset busy", o_busy, 1'b0);
    check("mid reset error", o_error, 1'b0);
    check("mid reset tdata", o_tdata, 8'h00);
    step();
    rstn = 1'b1;
    i_tready = 1'b1;
    rx_q.delete();
    step();
    send_pixels(8'hFF, 8'hFF, 8'h00, 20, 1'b0);
    vsync_pulse();
    repeat (20) step();
    check("post-reset no bytes", rx_q.size(), 0);
    check("post-reset busy", o_busy, 1'b0);
    check("post-reset tvalid", o_tvalid, 1'b0);
    start_frame();
    send_pixels(8'hFF, 8'hFF, 8'h00, H_RES, 1'b0);
    step();
    vsync_pulse();
    wait_idle("recapture idle", 200);
    check("recapture count", rx_q.size(), BPL);
    if (rx_q.size() == BPL) check("recapture last byte", rx_q[BPL-1][7:0], 8'hF0);
    $display("reset-recover: bytes=%0d", rx_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
